sr_reg_bank: RTL and testbench

SR_REG_BANK -- requirements
Module: sr_reg_bank

---
 rtl/sr_reg_bank.sv | 93 +++++++++
 tb/tb_sr_reg_bank.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sr_reg_bank.sv
// sr_reg_bank: a bank of independent, registered SR channels.
// Each channel resolves its s/r pair once per enabled clock edge. Simultaneous
// s=r=1 is resolved by CONFLICT_MODE and is recorded in a sticky per-channel
// flag and a saturating cycle counter.
module sr_reg_bank #(
  parameter int               WIDTH         = 8,
  parameter int               CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0] RST_VAL       = {WIDTH{1'b0}},
  parameter int               CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Illegal parameter values stop elaboration; there is no run-time fallback.
  generate
    if (CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_mode
      $error("sr_reg_bank: CONFLICT_MODE must be 0..3");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("sr_reg_bank: WIDTH must be 1..32");
    end
    if (CNT_W < 1) begin : g_bad_cntw
      $error("sr_reg_bank: CNT_W must be at least 1");
    end
  endgenerate

  // Next state of every channel from its current value and its s/r pair.
  function automatic logic [WIDTH-1:0] resolve(input logic [WIDTH-1:0] qc,
                                               input logic [WIDTH-1:0] s_i,
                                               input logic [WIDTH-1:0] r_i);
    logic [WIDTH-1:0] both;
    logic [WIDTH-1:0] conf_val;
    both = s_i & r_i;
    case (CONFLICT_MODE)
      0:       conf_val = qc;   // hold
      1:       conf_val = '1;   // set wins
      2:       conf_val = '0;   // reset wins
      default: conf_val = ~qc;  // toggle
    endcase
    return (qc & ~s_i & ~r_i) | (s_i & ~r_i) | (both & conf_val);
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + 1'b1;
  endfunction

  logic [WIDTH-1:0] q_p0;
  logic [WIDTH-1:0] conflict_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [WIDTH-1:0] both_now;

  assign both_now = s & r;

  // Stage p0: channel state, updated only on enabled edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_p0 <= RST_VAL;
    end else if (en) begin
      q_p0 <= resolve(q_p0, s, r);
    end
  end

  // Conflict bookkeeping; the clear takes priority over any new conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_p0 <= '0;
      cnt_p0      <= '0;
    end else if (clr_conflict) begin
      conflict_p0 <= '0;
      cnt_p0      <= '0;
    end else if (en) begin
      conflict_p0 <= conflict_p0 | both_now;
      if (|both_now) cnt_p0 <= sat_inc(cnt_p0);
    end
  end

  assign q            = q_p0;
  assign qbar         = ~q_p0;
  assign conflict     = conflict_p0;
  assign conflict_cnt = cnt_p0;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench for sr_reg_bank: four 4-bit instances (one per CONFLICT_MODE,
// 3-bit counter) share stimulus with an 8-bit instance using RST_VAL=8'hA5.
module tb_sr_reg_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [7:0] s;
  logic [7:0] r;

  logic [3:0] q0, q1, q2, q3, qb0, qb1, qb2, qb3, cf0, cf1, cf2, cf3;
  logic [2:0] cn0, cn1, cn2, cn3;
  logic [7:0] q8, qb8, cf8, cn8;

  int n_cmp = 0;
  int n_bad = 0;

  sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(0), .RST_VAL(4'h0), .CNT_W(3)) u0 (
    .clk(clk), .rst(rst), .en(en), .s(s[3:0]), .r(r[3:0]), .clr_conflict(clr),
    .q(q0), .qbar(qb0), .conflict(cf0), .conflict_cnt(cn0));
  sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(1), .RST_VAL(4'h0), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .en(en), .s(s[3:0]), .r(r[3:0]), .clr_conflict(clr),
    .q(q1), .qbar(qb1), .conflict(cf1), .conflict_cnt(cn1));
  sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(2), .RST_VAL(4'h0), .CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .en(en), .s(s[3:0]), .r(r[3:0]), .clr_conflict(clr),
    .q(q2), .qbar(qb2), .conflict(cf2), .conflict_cnt(cn2));
  sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(3), .RST_VAL(4'h0), .CNT_W(3)) u3 (
    .clk(clk), .rst(rst), .en(en), .s(s[3:0]), .r(r[3:0]), .clr_conflict(clr),
    .q(q3), .qbar(qb3), .conflict(cf3), .conflict_cnt(cn3));
  sr_reg_bank #(.WIDTH(8), .CONFLICT_MODE(0), .RST_VAL(8'hA5), .CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_conflict(clr),
    .q(q8), .qbar(qb8), .conflict(cf8), .conflict_cnt(cn8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       clr;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] q0;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [3:0] q3;
    logic [3:0] conf;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // en clr s r | q mode0 mode1 mode2 mode3 | conflict cnt
    tbl[0] = '{1'b1, 1'b0, 4'b1100, 4'b1010, 4'b0100, 4'b1100, 4'b0100, 4'b1100, 4'b1000, 3'd1};
    tbl[1] = '{1'b1, 1'b0, 4'b1100, 4'b1010, 4'b0100, 4'b1100, 4'b0100, 4'b0100, 4'b1000, 3'd2};
    tbl[2] = '{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0100, 4'b1100, 4'b0100, 4'b0100, 4'b1000, 3'd2};
    tbl[3] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1000, 3'd2};
    tbl[4] = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1001, 3'd3};
    tbl[5] = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1001, 3'd4};
    tbl[6] = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1001, 3'd5};
    tbl[7] = '{1'b1, 1'b1, 4'b0010, 4'b0010, 4'b1111, 4'b1111, 4'b1100, 4'b1100, 4'b0000, 3'd0};
    tbl[8] = '{1'b0, 1'b1, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1100, 4'b1100, 4'b0000, 3'd0};
    tbl[9] = '{1'b1, 1'b0, 4'b0000, 4'b0100, 4'b1011, 4'b1011, 4'b1000, 4'b1000, 4'b0000, 3'd0};

    rst = 1'b1; en = 1'b0; clr = 1'b0; s = 8'h00; r = 8'h00;
    tick();
    tick();
    chk("rst q0", {28'd0, q0}, 32'h0);
    chk("rst qb0", {28'd0, qb0}, 32'hF);
    chk("rst cf0", {28'd0, cf0}, 32'h0);
    chk("rst cn0", {29'd0, cn0}, 32'h0);
    chk("rst q8", {24'd0, q8}, 32'hA5);
    rst = 1'b0;

    // Truth table and per-mode conflict resolution
    for (int i = 0; i < 10; i++) begin
      en = tbl[i].en; clr = tbl[i].clr;
      s = {4'b0000, tbl[i].s}; r = {4'b0000, tbl[i].r};
      tick();
      chk($sformatf("v%0d q0", i), {28'd0, q0}, {28'd0, tbl[i].q0});
      chk($sformatf("v%0d q1", i), {28'd0, q1}, {28'd0, tbl[i].q1});
      chk($sformatf("v%0d q2", i), {28'd0, q2}, {28'd0, tbl[i].q2});
      chk($sformatf("v%0d q3", i), {28'd0, q3}, {28'd0, tbl[i].q3});
      chk($sformatf("v%0d qb2", i), {28'd0, qb2}, {28'd0, ~tbl[i].q2});
      chk($sformatf("v%0d cf0", i), {28'd0, cf0}, {28'd0, tbl[i].conf});
      chk($sformatf("v%0d cf3", i), {28'd0, cf3}, {28'd0, tbl[i].conf});
      chk($sformatf("v%0d cn0", i), {29'd0, cn0}, {29'd0, tbl[i].cnt});
      chk($sformatf("v%0d cn2", i), {29'd0, cn2}, {29'd0, tbl[i].cnt});
    end

    // Counter saturation at 7 with a 3-bit counter
    en = 1'b1; clr = 1'b0; s = 8'h08; r = 8'h08;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("sat%0d cn0", i), {29'd0, cn0}, (i < 6) ? i + 1 : 7);
    end
    tick();
    chk("sat hold cn1", {29'd0, cn1}, 32'd7);
    chk("sat q0", {28'd0, q0}, 32'hB);

    // Clear coinciding with a new conflict
    clr = 1'b1;
    tick();
    chk("clrwin cf0", {28'd0, cf0}, 32'h0);
    chk("clrwin cn0", {29'd0, cn0}, 32'h0);
    chk("clrwin q0", {28'd0, q0}, 32'hB);

    // Enable gating
    clr = 1'b0;
    tick();
    chk("pre-gate cf0", {28'd0, cf0}, 32'h8);
    chk("pre-gate cn0", {29'd0, cn0}, 32'h1);
    en = 1'b0; s = 8'h0F; r = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("gate%0d q0", i), {28'd0, q0}, 32'hB);
      chk($sformatf("gate%0d cf0", i), {28'd0, cf0}, 32'h8);
      chk($sformatf("gate%0d cn0", i), {29'd0, cn0}, 32'h1);
    end
    en = 1'b1;
    tick();
    chk("ungate q0", {28'd0, q0}, 32'hF);
    chk("ungate q2", {28'd0, q2}, 32'hF);

    // Asynchronous reset on the RST_VAL=8'hA5 instance
    rst = 1'b1;
    #1;
    chk("arst0 q8", {24'd0, q8}, 32'hA5);
    tick();
    rst = 1'b0; s = 8'hFF; r = 8'h01; en = 1'b1;
    tick();
    chk("load q8", {24'd0, q8}, 32'hFF);
    chk("load cf8", {24'd0, cf8}, 32'h01);
    chk("load cn8", {24'd0, cn8}, 32'h01);
    #3;
    rst = 1'b1;
    #1;
    chk("arst q8", {24'd0, q8}, 32'hA5);
    chk("arst qb8", {24'd0, qb8}, 32'h5A);
    chk("arst cf8", {24'd0, cf8}, 32'h0);
    chk("arst cn8", {24'd0, cn8}, 32'h0);
    chk("arst q0", {28'd0, q0}, 32'h0);
    tick();
    chk("rst override q8", {24'd0, q8}, 32'hA5);
    chk("rst override cf8", {24'd0, cf8}, 32'h0);
    rst = 1'b0; s = 8'h01; r = 8'h00;
    tick();
    chk("post-rst q8", {24'd0, q8}, 32'hA5);
    chk("post-rst qb8", {24'd0, qb8}, 32'h5A);
    chk("post-rst q0", {28'd0, q0}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
